// File: rtl/eucl_pkg.sv
// Shared constants, instruction field positions and FSM state type for eucl_core.
package eucl_pkg;

  localparam int DW   = 8;
  localparam int PCW  = 4;
  localparam int NREG = 8;
  localparam int RAW  = 3;
  localparam int IW   = 21;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_LDI = 4'b0010;
  localparam logic [3:0] OP_GCD = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_MOD = 4'b0111;
  localparam logic [3:0] OP_OUT = 4'b1010;

  localparam int IMM_MSB = 20;
  localparam int IMM_LSB = 13;
  localparam int RA_MSB  = 12;
  localparam int RA_LSB  = 10;
  localparam int RB_MSB  = 9;
  localparam int RB_LSB  = 7;
  localparam int RD_MSB  = 6;
  localparam int RD_LSB  = 4;
  localparam int OP_MSB  = 3;
  localparam int OP_LSB  = 0;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

endpackage

// File: rtl/eucl_regfile.sv
// 8x8 register file: two asynchronous read ports, one synchronous write port.
module eucl_regfile
  import eucl_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic [RAW-1:0] addr_a,
  input  logic [RAW-1:0] addr_b,
  output logic [DW-1:0]  data_a,
  output logic [DW-1:0]  data_b,
  input  logic           we,
  input  logic [RAW-1:0] addr_w,
  input  logic [DW-1:0]  data_w
);

  logic [DW-1:0] mem [NREG];

  // Clear every register on reset, otherwise perform the single write.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr_w] <= data_w;
    end
  end

  assign data_a = mem[addr_a];
  assign data_b = mem[addr_b];

endmodule

// File: rtl/eucl_core.sv
// Single-issue 8-bit datapath with iterative GCD and MOD that stall the PC.
// Handshake: none; the PC is the only flow control. While BUSY, p_c_out
// returns p_c so the fetch loop re-presents the same instruction.
module eucl_core
  import eucl_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [IW-1:0]   pm_cont,
  input  logic [PCW-1:0]  p_c,
  output logic [PCW-1:0]  p_c_out,
  output logic [DW-1:0]   dataout,
  output state_t          fsm_state
);

  logic [DW-1:0]  imm;
  logic [RAW-1:0] ra, rb, rd;
  logic [3:0]     op;

  assign imm = pm_cont[IMM_MSB:IMM_LSB];
  assign ra  = pm_cont[RA_MSB:RA_LSB];
  assign rb  = pm_cont[RB_MSB:RB_LSB];
  assign rd  = pm_cont[RD_MSB:RD_LSB];
  assign op  = pm_cont[OP_MSB:OP_LSB];

  state_t         state_q, state_d;
  logic [DW-1:0]  a_q, b_q, a_nx, b_nx, res;
  logic [RAW-1:0] rd_q;
  logic [3:0]     op_q;
  logic           fin;

  logic [DW-1:0]  data_a, data_b, wd;
  logic [RAW-1:0] wa;
  logic           we, load, out_en;
  logic [PCW-1:0] pc_next;

  eucl_regfile u_regfile (
    .clock  (clock),
    .reset  (reset),
    .addr_a (ra),
    .addr_b (rb),
    .data_a (data_a),
    .data_b (data_b),
    .we     (we),
    .addr_w (wa),
    .data_w (wd)
  );

  assign fsm_state = state_q;

  // One iteration step of the latched GCD or MOD operation.
  always_comb begin
    fin  = 1'b0;
    res  = a_q;
    a_nx = a_q;
    b_nx = b_q;
    if (op_q == OP_GCD) begin
      if ((a_q == b_q) || (a_q == '0) || (b_q == '0)) begin
        fin = 1'b1;
        res = a_q | b_q;
      end else if (a_q > b_q) begin
        a_nx = a_q - b_q;
      end else begin
        b_nx = b_q - a_q;
      end
    end else begin
      if ((b_q == '0) || (a_q < b_q)) begin
        fin = 1'b1;
      end else begin
        a_nx = a_q - b_q;
      end
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: enter BUSY on an iterative op, leave when the step finishes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if ((op == OP_GCD) || (op == OP_MOD)) state_d = BUSY;
      BUSY:    if (fin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: register-file write, operand latch, OUT enable and next PC.
  always_comb begin
    we      = 1'b0;
    wa      = rd;
    wd      = '0;
    load    = 1'b0;
    out_en  = 1'b0;
    pc_next = p_c + PCW'(1);
    case (state_q)
      IDLE: begin
        case (op)
          OP_MOV: begin we = 1'b1; wd = data_a; end
          OP_LDI: begin we = 1'b1; wa = ra; wd = imm; end
          OP_ADD: begin we = 1'b1; wd = data_a + data_b; end
          OP_SUB: begin we = 1'b1; wd = data_a - data_b; end
          OP_GCD, OP_MOD: begin load = 1'b1; pc_next = p_c; end
          OP_OUT: out_en = 1'b1;
          default: ;
        endcase
      end
      BUSY: begin
        if (fin) begin
          we = 1'b1;
          wa = rd_q;
          wd = res;
        end else begin
          pc_next = p_c;
        end
      end
      default: ;
    endcase
  end

  // PC, output port and iteration operand registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      p_c_out <= '0;
      dataout <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      op_q    <= OP_NOP;
    end else begin
      p_c_out <= pc_next;
      if (out_en) dataout <= data_a;
      if (load) begin
        a_q  <= data_a;
        b_q  <= data_b;
        rd_q <= rd;
        op_q <= op;
      end else if (state_q == BUSY) begin
        a_q <= a_nx;
        b_q <= b_nx;
      end
    end
  end

endmodule

// File: tb/tb_eucl_core.sv
// Self-checking bench for eucl_core: directed program plus random instructions
// against an instruction-level reference model.
module tb_eucl_core;
  import eucl_pkg::*;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [IW-1:0]  pm_cont = '0;
  logic [PCW-1:0] p_c = '0;
  logic [PCW-1:0] p_c_out;
  logic [DW-1:0]  dataout;
  state_t         fsm_state;

  eucl_core dut (
    .clock     (clock),
    .reset     (reset),
    .pm_cont   (pm_cont),
    .p_c       (p_c),
    .p_c_out   (p_c_out),
    .dataout   (dataout),
    .fsm_state (fsm_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  // reference model state
  logic [DW-1:0]  m_reg [NREG];
  logic [DW-1:0]  m_dout;
  logic [PCW-1:0] m_pc;
  logic [DW-1:0]  exp_q [$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] enc(input logic [3:0] op, input int ra, input int rb,
                                       input int rd, input int imm);
    logic [IW-1:0] w;
    w = '0;
    w[IMM_MSB:IMM_LSB] = imm[7:0];
    w[RA_MSB:RA_LSB]   = ra[2:0];
    w[RB_MSB:RB_LSB]   = rb[2:0];
    w[RD_MSB:RD_LSB]   = rd[2:0];
    w[OP_MSB:OP_LSB]   = op;
    return w;
  endfunction

  // Greatest common divisor by remainders (gcd(0,x)=x, gcd(0,0)=0).
  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Number of subtract-the-smaller steps before the stop condition holds.
  function automatic int gcd_steps(input int a, input int b);
    int n = 0;
    while (!(a == b || a == 0 || b == 0)) begin
      if (a > b) a = a - b;
      else       b = b - a;
      n++;
    end
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    m_dout = '0;
    m_pc   = '0;
  endtask

  // driver: present one instruction at the model PC and check every edge it spans
  task automatic run_instr(input logic [IW-1:0] ins);
    logic [3:0] op;
    int ra, rb, rd, imm, a, b, stalls, result;
    logic [DW-1:0] ev;
    op  = ins[OP_MSB:OP_LSB];
    ra  = int'(ins[RA_MSB:RA_LSB]);
    rb  = int'(ins[RB_MSB:RB_LSB]);
    rd  = int'(ins[RD_MSB:RD_LSB]);
    imm = int'(ins[IMM_MSB:IMM_LSB]);
    @(negedge clock);
    pm_cont = ins;
    p_c     = m_pc;
    if (op == OP_GCD || op == OP_MOD) begin
      a = int'(m_reg[ra]);
      b = int'(m_reg[rb]);
      if (op == OP_GCD) begin
        result = ref_gcd(a, b);
        stalls = 1 + gcd_steps(a, b);
      end else begin
        result = (b == 0) ? a : a % b;
        stalls = 1 + ((b == 0) ? 0 : a / b);
      end
      for (int i = 0; i < stalls; i++) begin
        @(posedge clock); #1;
        check_eq("stall_pc", 32'(p_c_out), 32'(m_pc));
        check_eq("stall_busy", 32'(fsm_state), 32'(BUSY));
      end
      m_reg[rd] = result[7:0];
    end else begin
      case (op)
        OP_MOV: m_reg[rd] = m_reg[ra];
        OP_LDI: m_reg[ra] = imm[7:0];
        OP_ADD: m_reg[rd] = 8'((int'(m_reg[ra]) + int'(m_reg[rb])) % 256);
        OP_SUB: m_reg[rd] = 8'((int'(m_reg[ra]) - int'(m_reg[rb]) + 256) % 256);
        OP_OUT: exp_q.push_back(m_reg[ra]);
        default: ;
      endcase
    end
    @(posedge clock); #1;
    m_pc = m_pc + 4'd1;
    check_eq("pc_next", 32'(p_c_out), 32'(m_pc));
    check_eq("idle", 32'(fsm_state), 32'(IDLE));
    if (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      m_dout = ev;
    end
    check_eq("dataout", 32'(dataout), 32'(m_dout));
  endtask

  task automatic dump_regs();
    for (int i = 0; i < NREG; i++) run_instr(enc(OP_OUT, i, 0, 0, 0));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    pm_cont = '0;
    @(posedge clock); @(posedge clock); #1;
    model_reset();
    check_eq("rst_pc", 32'(p_c_out), 32'(m_pc));
    check_eq("rst_dout", 32'(dataout), 32'(m_dout));
    check_eq("rst_state", 32'(fsm_state), 32'(IDLE));
    @(negedge clock);
    reset = 1'b0;
  endtask

  logic [3:0] op_tab [12];

  initial begin
    op_tab = '{OP_NOP, OP_MOV, OP_LDI, OP_GCD, OP_ADD, OP_SUB, OP_MOD, OP_OUT,
               4'b0110, 4'b1000, 4'b1011, 4'b1111};
    model_reset();
    do_reset();

    // NOP at pc 0
    run_instr(enc(OP_NOP, 0, 0, 0, 0));
    // LDI / OUT
    run_instr(enc(OP_LDI, 3, 0, 0, 84));
    run_instr(enc(OP_OUT, 3, 0, 0, 0));
    check_eq("out_84", 32'(dataout), 32'd84);
    // GCD(36,24) -> 12
    run_instr(enc(OP_LDI, 2, 0, 0, 36));
    run_instr(enc(OP_LDI, 3, 0, 0, 24));
    run_instr(enc(OP_GCD, 2, 3, 3, 0));
    run_instr(enc(OP_OUT, 3, 0, 0, 0));
    check_eq("gcd_36_24", 32'(dataout), 32'd12);
    // remainder of 84 by 10, and remainder with a zero divisor
    run_instr(enc(OP_LDI, 1, 0, 0, 84));
    run_instr(enc(OP_LDI, 4, 0, 0, 10));
    run_instr(enc(OP_MOD, 1, 4, 5, 0));
    run_instr(enc(OP_OUT, 5, 0, 0, 0));
    check_eq("mod_84_10", 32'(dataout), 32'd4);
    run_instr(enc(OP_LDI, 6, 0, 0, 0));
    run_instr(enc(OP_MOD, 1, 6, 7, 0));
    run_instr(enc(OP_OUT, 7, 0, 0, 0));
    check_eq("mod_by_0", 32'(dataout), 32'd84);
    // GCD equal operands, gcd(0,0), write to R0
    run_instr(enc(OP_GCD, 1, 1, 0, 0));
    run_instr(enc(OP_GCD, 6, 6, 2, 0));
    dump_regs();

    // PC wrap
    m_pc = 4'd15;
    run_instr(enc(OP_NOP, 0, 0, 0, 0));
    check_eq("pc_wrap", 32'(p_c_out), 32'd0);

    // random instructions
    for (int n = 0; n < 300; n++) begin
      logic [3:0] op;
      op = op_tab[$urandom_range(0, 11)];
      if ($urandom_range(0, 3) == 0) op = OP_LDI;
      run_instr(enc(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    ($urandom_range(0, 1) == 1) ? $urandom_range(0, 255) : $urandom_range(0, 12)));
      if (n % 50 == 49) dump_regs();
    end

    // reset during a GCD stall
    for (int i = 0; i < NREG; i++) run_instr(enc(OP_LDI, i, 0, 0, 200 + i));
    run_instr(enc(OP_OUT, 5, 0, 0, 0));
    run_instr(enc(OP_LDI, 1, 0, 0, 1));
    @(negedge clock);
    pm_cont = enc(OP_GCD, 0, 1, 4, 0);
    p_c     = m_pc;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    model_reset();
    check_eq("midrst_pc", 32'(p_c_out), 32'(m_pc));
    check_eq("midrst_dout", 32'(dataout), 32'(m_dout));
    check_eq("midrst_state", 32'(fsm_state), 32'(IDLE));
    @(negedge clock);
    reset = 1'b0;
    dump_regs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
